pdp8l_tty_uart: RTL and testbench

Hardware serial-line front end for the PDP-8/L teletype interface. It drives the interface's arm-side register port the way ARM software otherwise would. Printer characters posted by the PDP-8/L are serialized out a TX pin, with done status returned afterwards. Characters received on an RX pin are deserialized and posted as keyboard characters. It sits beside the teletype interface in the Zynq fabric and owns that interface's arm read/write port.

---
 rtl/pdp8l_tty_uart.sv | 199 +++++++++++++++++++
 tb/tb_pdp8l_tty_uart.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp8l_tty_uart.sv
// Serial-line front end for the PDP-8/L teletype interface: polls the interface's
// arm register port, shifts printer characters out on txd and posts rxd characters as keyboard input.
module pdp8l_tty_uart #(
  parameter int CLKDIV = 10417
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        enable,
  input  logic        rxd,
  output logic        txd,
  output logic        armwrite,
  output logic [1:0]  armwaddr,
  output logic [31:0] armwdata,
  output logic [1:0]  armraddr,
  input  logic [31:0] armrdata,
  output logic        rxoverrun,
  output logic        framerr
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKDIV / 2 - 1);

  typedef enum logic [2:0] {B_INIT, B_RD2, B_CK2, B_RD1, B_CK1} bus_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  bus_state_t  bus_state;
  logic        txdonepend;
  logic        tx_busy;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bitn;
  logic [8:0]  tx_shift;

  logic        rxd_s1, rxd_s2, rx_last;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bitn;
  logic [7:0]  rx_shift;
  logic [7:0]  rxhold;
  logic        rxvalid;

  logic        kb_consume, tx_start, tx_end;
  logic        unused_rdata;

  function automatic logic [31:0] reg1_word(input logic kbflag, input logic en,
                                            input logic [7:0] ch);
    return {kbflag, en, 22'b0, ch};
  endfunction

  always_comb begin
    kb_consume   = (bus_state == B_CK1) && rxvalid && !armrdata[31];
    tx_start     = (bus_state == B_CK2) && !txdonepend && armrdata[30] && !tx_busy;
    tx_end       = tx_busy && (tx_cnt == 16'd0) && (tx_bitn == 4'd9);
    unused_rdata = ^armrdata[29:8];
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      bus_state  <= B_INIT;
      armwrite   <= 1'b0;
      armwaddr   <= 2'd0;
      armwdata   <= 32'd0;
      armraddr   <= 2'd0;
      txdonepend <= 1'b0;
      tx_busy    <= 1'b0;
      tx_cnt     <= 16'd0;
      tx_bitn    <= 4'd0;
      tx_shift   <= 9'd0;
      txd        <= 1'b1;
      rxd_s1     <= 1'b1;
      rxd_s2     <= 1'b1;
      rx_last    <= 1'b1;
      rx_state   <= R_IDLE;
      rx_cnt     <= 16'd0;
      rx_bitn    <= 3'd0;
      rx_shift   <= 8'd0;
      rxhold     <= 8'd0;
      rxvalid    <= 1'b0;
      rxoverrun  <= 1'b0;
      framerr    <= 1'b0;
    end else begin
      armwrite <= 1'b0;
      case (bus_state)
        B_INIT: begin
          armwrite  <= 1'b1;
          armwaddr  <= 2'd1;
          armwdata  <= reg1_word(1'b0, enable, 8'h00);
          bus_state <= B_RD2;
        end
        B_RD2: begin
          armraddr  <= 2'd2;
          bus_state <= B_CK2;
        end
        B_CK2: begin
          if (txdonepend) begin
            armwrite <= 1'b1;
            armwaddr <= 2'd2;
            armwdata <= 32'h8000_0000;
          end
          bus_state <= B_RD1;
        end
        B_RD1: begin
          armraddr  <= 2'd1;
          bus_state <= B_CK1;
        end
        B_CK1: begin
          if (kb_consume) begin
            armwrite <= 1'b1;
            armwaddr <= 2'd1;
            armwdata <= reg1_word(1'b1, enable, rxhold);
          end
          bus_state <= B_RD2;
        end
        default: bus_state <= B_INIT;
      endcase

      // Transmitter: tx_shift holds the remaining data bits with the stop bit on top
      if (tx_start) begin
        tx_busy  <= 1'b1;
        tx_cnt   <= BIT_LAST;
        tx_bitn  <= 4'd0;
        tx_shift <= {1'b1, armrdata[7:0]};
        txd      <= 1'b0;
      end else if (tx_busy) begin
        if (tx_cnt != 16'd0) begin
          tx_cnt <= tx_cnt - 16'd1;
        end else if (tx_bitn == 4'd9) begin
          tx_busy <= 1'b0;
          txd     <= 1'b1;
        end else begin
          tx_cnt   <= BIT_LAST;
          tx_bitn  <= tx_bitn + 4'd1;
          txd      <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
        end
      end

      if (tx_end)
        txdonepend <= 1'b1;
      else if (bus_state == B_CK2 && txdonepend)
        txdonepend <= 1'b0;

      // Receiver: consume clears rxvalid first so a byte landing the same cycle still loads
      rxd_s1  <= rxd;
      rxd_s2  <= rxd_s1;
      rx_last <= rxd_s2;
      if (kb_consume)
        rxvalid <= 1'b0;

      case (rx_state)
        R_IDLE: begin
          if (rx_last && !rxd_s2) begin
            rx_state <= R_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        R_START: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else if (rxd_s2) begin
            rx_state <= R_IDLE;
          end else begin
            rx_state <= R_DATA;
            rx_cnt   <= BIT_LAST;
            rx_bitn  <= 3'd0;
          end
        end
        R_DATA: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_shift <= {rxd_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_bitn == 3'd7)
              rx_state <= R_STOP;
            else
              rx_bitn <= rx_bitn + 3'd1;
          end
        end
        R_STOP: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_state <= R_IDLE;
            if (!rxd_s2) begin
              framerr <= 1'b1;
            end else if (rxvalid && !kb_consume) begin
              rxoverrun <= 1'b1;
            end else begin
              rxhold  <= rx_shift;
              rxvalid <= 1'b1;
            end
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8l_tty_uart.sv
// Bench for pdp8l_tty_uart: models the teletype interface registers and the PDP side,
// drives random serial traffic and compares against frame-level expectations.
module tb_pdp8l_tty_uart;

  localparam int CLKDIV = 16;
  localparam int MID_STOP = 9 * CLKDIV + CLKDIV / 2;

  logic        CLOCK = 1'b0;
  logic        RESET, enable, rxd;
  logic        txd, armwrite, rxoverrun, framerr;
  logic [1:0]  armwaddr, armraddr;
  logic [31:0] armwdata, armrdata;

  logic [31:0] reg1, reg2;
  int          pdp_op;
  logic [31:0] pdp_val;
  int          cyc;
  int          ntests, nfail;
  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  pdp8l_tty_uart #(.CLKDIV(CLKDIV)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .enable(enable), .rxd(rxd), .txd(txd),
    .armwrite(armwrite), .armwaddr(armwaddr), .armwdata(armwdata),
    .armraddr(armraddr), .armrdata(armrdata),
    .rxoverrun(rxoverrun), .framerr(framerr)
  );

  always #5 CLOCK = ~CLOCK;

  assign armrdata = (armraddr == 2'd1) ? reg1 : (armraddr == 2'd2) ? reg2 : 32'h0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Teletype interface registers plus PDP-side actions (1: set reg1, 2: set reg2, 3: clear kbflag)
  always @(negedge CLOCK) begin
    if (RESET) begin
      reg1 <= 32'h0;
      reg2 <= 32'h0;
    end else begin
      if (armwrite) begin
        wq_addr.push_back(int'(armwaddr));
        wq_data.push_back(armwdata);
        wq_cyc.push_back(cyc);
        if (armwaddr == 2'd1) reg1 <= armwdata;
        else if (armwaddr == 2'd2) reg2 <= armwdata;
      end
      if (pdp_op == 1) reg1 <= pdp_val;
      else if (pdp_op == 2) reg2 <= pdp_val;
      else if (pdp_op == 3) reg1 <= reg1 & 32'h7FFF_FFFF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic pdp(input int op, input logic [31:0] v);
    @(posedge CLOCK);
    pdp_op  = op;
    pdp_val = v;
    @(posedge CLOCK);
    pdp_op  = 0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, output int fall_cyc);
    @(negedge CLOCK);
    rxd = 1'b0;
    fall_cyc = cyc;
    tick(CLKDIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CLKDIV);
    end
    rxd = stopb;
    tick(CLKDIV);
    rxd = 1'b1;
    tick(4);
  endtask

  task automatic expect_kb(input string tag, input int base, input logic [7:0] b, input int fall);
    int lat;
    chk({tag, "_nwr"}, wq_addr.size() - base, 1);
    if (wq_addr.size() > base) begin
      chk({tag, "_addr"}, wq_addr[base], 1);
      chk({tag, "_data"}, wq_data[base], {1'b1, enable, 22'b0, b});
      lat = wq_cyc[base] - fall;
      chk({tag, "_lat"}, (lat >= MID_STOP && lat <= MID_STOP + 10), 1);
    end
  endtask

  task automatic wait_txd_low(input int limit, output int found);
    found = 0;
    for (int i = 0; i < limit && found == 0; i++) begin
      @(negedge CLOCK);
      if (txd == 1'b0) found = 1;
    end
  endtask

  task automatic run_tx(input string tag, input logic [7:0] b);
    int base, found, good, stop_cyc;
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    base  = wq_addr.size();
    pdp(2, 32'h4000_0000 | 32'(b));
    wait_txd_low(40, found);
    chk({tag, "_start"}, found, 1);
    if (found == 1) begin
      for (int k = 0; k < 10; k++) begin
        good = 0;
        for (int j = 0; j < CLKDIV; j++) begin
          if (txd === frame[k]) good++;
          @(negedge CLOCK);
        end
        chk($sformatf("%s_bit%0d", tag, k), good, CLKDIV);
      end
      stop_cyc = cyc;
      tick(8);
      chk({tag, "_nwr"}, wq_addr.size() - base, 1);
      if (wq_addr.size() > base) begin
        chk({tag, "_addr"}, wq_addr[base], 2);
        chk({tag, "_data"}, wq_data[base], 32'h8000_0000);
        chk({tag, "_lat"}, (wq_cyc[base] - stop_cyc) inside {[0:8]}, 1);
      end
      good = 0;
      for (int j = 0; j < 24; j++) begin
        if (txd !== 1'b1) good++;
        @(negedge CLOCK);
      end
      chk({tag, "_idle"}, good, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rsamp[16];
    int first2, base, fall, found, lows;
    logic [7:0] b;
    ntests = 0;
    nfail  = 0;
    RESET  = 1'b1;
    enable = 1'b1;
    rxd    = 1'b1;
    pdp_op = 0;
    pdp_val = 32'h0;
    tick(3);
    chk("rst_txd", txd, 1);
    chk("rst_armwrite", armwrite, 0);
    chk("rst_armwaddr", armwaddr, 0);
    chk("rst_armwdata", armwdata, 0);
    chk("rst_armraddr", armraddr, 0);
    chk("rst_rxoverrun", rxoverrun, 0);
    chk("rst_framerr", framerr, 0);

    RESET = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK);
      rsamp[i] = int'(armraddr);
    end
    first2 = -1;
    for (int i = 0; i < 16; i++)
      if (first2 < 0 && rsamp[i] == 2) first2 = i;
    chk("raddr_found", (first2 >= 0 && first2 < 4), 1);
    if (first2 >= 0 && first2 <= 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("raddr%0d", i), rsamp[first2 + i], ((i % 4) < 2) ? 2 : 1);
    chk("init_nwr", wq_addr.size(), 1);
    if (wq_addr.size() > 0) begin
      chk("init_addr", wq_addr[0], 1);
      chk("init_data", wq_data[0], 32'h4000_0000);
    end

    run_tx("tx41", 8'h41);
    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom);
      run_tx($sformatf("txr%0d", n), b);
    end

    base = wq_addr.size();
    send_rx(8'h5A, 1'b1, fall);
    expect_kb("rx5a", base, 8'h5A, fall);
    for (int n = 0; n < 3; n++) begin
      pdp(3, 32'h0);
      b = 8'($urandom);
      base = wq_addr.size();
      send_rx(b, 1'b1, fall);
      expect_kb($sformatf("rxr%0d", n), base, b, fall);
    end
    chk("rx_no_overrun", rxoverrun, 0);
    chk("rx_no_framerr", framerr, 0);

    base = wq_addr.size();
    send_rx(8'h31, 1'b1, fall);
    send_rx(8'h32, 1'b1, fall);
    chk("ovr_nwr", wq_addr.size() - base, 0);
    chk("ovr_flag", rxoverrun, 1);
    pdp(3, 32'h0);
    tick(8);
    chk("ovr_release_nwr", wq_addr.size() - base, 1);
    if (wq_addr.size() > base) chk("ovr_release_data", wq_data[base], 32'hC000_0031);
    tick(40);
    chk("ovr_dropped", wq_addr.size() - base, 1);

    pdp(3, 32'h0);
    base = wq_addr.size();
    send_rx(8'h55, 1'b0, fall);
    tick(4);
    chk("fe_nwr", wq_addr.size() - base, 0);
    chk("fe_flag", framerr, 1);
    chk("fe_ovr_sticky", rxoverrun, 1);
    send_rx(8'h20, 1'b1, fall);
    expect_kb("fe_next", base, 8'h20, fall);

    b = 8'($urandom) & 8'hEF;
    pdp(2, 32'h4000_0000 | 32'(b));
    wait_txd_low(40, found);
    chk("rsttx_start", found, 1);
    tick(88);
    chk("rsttx_bit4", txd, 0);
    base = wq_addr.size();
    RESET = 1'b1;
    @(negedge CLOCK);
    chk("rsttx_txd", txd, 1);
    tick(1);
    RESET = 1'b0;
    lows = 0;
    for (int j = 0; j < 12 * CLKDIV; j++) begin
      if (txd !== 1'b1) lows++;
      @(negedge CLOCK);
    end
    chk("rsttx_idle", lows, 0);
    chk("rsttx_nwr", wq_addr.size() - base, 1);
    if (wq_addr.size() > base) begin
      chk("rsttx_init_addr", wq_addr[base], 1);
      chk("rsttx_init_data", wq_data[base], 32'h4000_0000);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
